serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new addition; sampled only when accepted (REQ-012).
REQ-005 SHALL have port: a_in  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum_out  output  WIDTH  result; held stable from done until next accepted start.
REQ-011 SHALL have port: cout  output  1  final carry-out; held stable with sum_out.

Function
REQ-012 SHALL use FSM states IDLE, RUN, DONE; start is accepted in IDLE or DONE, ignored in RUN.
REQ-013 SHALL, on accepted start: load A/B shift registers, carry register <= cin, bit counter <= 0, go to RUN.
REQ-014 SHALL, each RUN cycle: add A[0], B[0], carry via one full-adder cell, shift sum bit into result MSB, shift A/B right, update carry, increment counter.
REQ-015 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1 at the last bit).
REQ-016 SHALL produce a result equal to (a_in + b_in + cin) mod 2^WIDTH on sum_out and bit WIDTH of that sum on cout.
REQ-017 SHALL assert done for exactly the DONE cycle: start accepted at edge 0 -> done high after edge WIDTH+1.
REQ-018 SHALL drive busy high in RUN only; busy and done never high together.
REQ-019 SHALL, in DONE with start high, restart immediately (DONE -> RUN); otherwise DONE -> IDLE.
REQ-020 SHALL update sum_out/cout only on the RUN->DONE transition; intermediate shifting is internal.
REQ-021 SHALL ignore a_in/b_in/cin changes outside an accepted-start cycle.

Reset
REQ-022 SHALL, when rst_n is low at a clock edge, go to IDLE and clear sum_out, cout, done, busy, counter, carry and shift registers, including mid-RUN.
REQ-023 SHALL ignore start while rst_n is low; first acceptable start is the cycle after rst_n returns high.

Configuration
REQ-024 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add port ovf  output  1, signed overflow = carry into MSB XOR cout, captured with sum_out, reset to 0.
REQ-025 SHALL, without SERIAL_ADDER_OVF_EN, omit the ovf port and its logic entirely; all other behaviour unchanged.

Structure
REQ-026 SHALL place FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH in the shared package serial_adder_pkg.
REQ-027 SHALL implement the per-bit adder as sub-module full_adder_cell (two half-adder stages plus OR for carry), instantiated once.
REQ-028 SHALL size the bit counter as clog2(WIDTH) bits.

Verification
REQ-029 SHALL cover: WIDTH=8, a=0x0F b=0x01 cin=0 -> sum_out=0x10 cout=0, done exactly 9 edges after start edge.
REQ-030 SHALL cover: a=0xFF b=0x01 cin=0 -> sum_out=0x00 cout=1; a=0xFF b=0xFF cin=1 -> sum_out=0xFF cout=1.
REQ-031 SHALL cover: with SERIAL_ADDER_OVF_EN, a=0x7F b=0x01 -> sum_out=0x80 ovf=1; a=0x80 b=0x80 -> 0x00 cout=1 ovf=1.
REQ-032 SHALL cover: start pulsed with a=0x55 mid-RUN of 0x12+0x34 -> ignored, result 0x46, single done.
REQ-033 SHALL cover: rst_n low for 1 cycle at RUN bit 4 -> busy=0, sum_out=0x00, no done; next start completes normally.
REQ-034 SHALL cover: start held high through DONE -> back-to-back operations, done every 9 cycles, each result correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int SA_DEFAULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR for the carry.
// The serial adder reuses this single cell once per clock for every bit.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: a + b.
    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;

    // Second half adder: partial sum + carry-in.
    assign o_sum = w_s1 ^ i_cin;
    assign w_c2  = w_s1 & i_cin;

    // Either stage may generate the carry, never both.
    assign o_cout = w_c1 | w_c2;

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus a carry-in, then adds
// one bit per clock (LSB first) through a single full-adder cell. The result
// and carry-out are published together with a one-cycle done pulse.
//
// Configuration: define SERIAL_ADDER_OVF_EN to add the signed-overflow output
// `ovf`. Without it the port and its logic are absent.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_sum;
    logic             w_carry;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    // The one shared full-adder cell working on the current LSBs.
    full_adder_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    // A new request is only taken when no addition is in flight.
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at LSB.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Controller, datapath shift registers and registered outputs in one process.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shift registers are ordinary flops, not a memory, so
            // clearing them with the rest of the state costs nothing and keeps
            // an aborted addition from leaking partial bits.
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum_out <= '0;
            r_cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register below see the
            // pre-edge values, so the shifts and the adder stay in lockstep.
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a_in;
                r_b     <= b_in;
                r_res   <= '0;
                r_carry <= cin;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_res   <= w_res_next;
                        r_carry <= w_carry;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_sum_out <= w_res_next;
                            r_cout    <= w_carry;
`ifdef SERIAL_ADDER_OVF_EN
                            // Carry into the MSB is the carry register at the last bit.
                            r_ovf     <= r_carry ^ w_carry;
`endif
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum_out;
    assign cout    = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf     = r_ovf;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8): a table of directed
// additions plus hand-written sequences for restart, mid-run start and
// mid-run reset. Build with SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait edges (sampled 1 time unit after each rising edge) until done is
    // seen or the budget runs out; returns the number of edges waited.
    task automatic wait_done(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    // One complete addition. Edge 0 is the edge after which start is raised;
    // the result must appear with done after edge W+1. Operands are scrambled
    // once start has been taken to show they are not resampled.
    task automatic do_op(input string name, input vec_t v);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = v.a;
        b_in  = v.b;
        cin   = v.c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = ~v.a;
        b_in  = v.b ^ 8'h5A;
        cin   = ~v.c;
        check({name, " busy_in_run"}, {31'd0, busy}, 32'd1);
        wait_done(40, n, seen);
        check({name, " latency"}, n + 1, W + 1);
        check({name, " sum"}, {24'd0, sum_out}, {24'd0, v.exp_sum});
        check({name, " cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({name, " ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
`endif
        @(posedge clk);
        #1;
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, " sum_held"}, {24'd0, sum_out}, {24'd0, v.exp_sum});
    endtask

    initial begin
        int  n;
        int  pulses;
        bit  seen;
        logic [W-1:0] seen_sum;

        // {a, b, cin, expected sum, expected cout, expected signed overflow}
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset with start held high: start must be ignored while in reset.
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 8'h33;
        b_in  = 8'h44;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset sum", {24'd0, sum_out}, 32'd0);
        check("reset cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", {31'd0, ovf}, 32'd0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset idle", {31'd0, busy}, 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Start pulsed mid-run must be ignored: 0x12 + 0x34 still gives 0x46.
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        a_in  = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'h00;
        check("midstart busy", {31'd0, busy}, 32'd1);
        pulses   = 0;
        seen_sum = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                seen_sum = sum_out;
            end
        end
        check("midstart done_count", pulses, 1);
        check("midstart sum", {24'd0, seen_sum}, 32'h46);

        // Reset for one cycle after four bits have been processed.
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'h0F;
        b_in  = 8'h01;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset sum", {24'd0, sum_out}, 32'd0);
        check("midreset cout", {31'd0, cout}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (busy) pulses++;
        end
        check("midreset no_done_no_busy", pulses, 0);
        do_op("after_reset", vecs[0]);

        // Start held high through DONE: back-to-back additions every W+1 edges.
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = vecs[3].a;
        b_in  = vecs[3].b;
        cin   = vecs[3].c;
        for (int k = 0; k < 3; k++) begin
            wait_done(40, n, seen);
            check($sformatf("b2b%0d period", k), n, W + 1);
            check($sformatf("b2b%0d sum", k), {24'd0, sum_out}, {24'd0, vecs[3 + k].exp_sum});
            check($sformatf("b2b%0d cout", k), {31'd0, cout}, {31'd0, vecs[3 + k].exp_cout});
            check($sformatf("b2b%0d busy_at_done", k), {31'd0, busy}, 32'd0);
            if (k < 2) begin
                a_in = vecs[4 + k].a;
                b_in = vecs[4 + k].b;
                cin  = vecs[4 + k].c;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b final done_low", {31'd0, done}, 32'd0);
        check("b2b final busy_low", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_adder
